// File: rtl/fir_coeff_sequencer.sv
// -----------------------------------------------------------------------------
// fir_coeff_sequencer
// Upstream control stage for the reconfigurable FIR filter. It divides the
// 12 MHz clock down to a 600 kHz sample strobe. It turns a valid/ready stream
// of 16-bit coefficients into the RAM write sequence (NUM_MODULES x NUM_TAPS).
// Between loads it drives the filter's run-mode controls.
//
// Ports:
//   iClk12M, iRsn         clock, asynchronous active-low reset
//   iLoadStart            pulse: begin a full coefficient load
//   iRunEn, iRunSel       run-mode enable and module select
//   iCoeffValid/Data      coefficient stream in; oCoeffReady handshake out
//   oEnSample600k         one-cycle sample strobe every SAMPLE_DIV cycles
//   oCoeffUpdateFlag      load in progress (LOAD and DONE)
//   oMemRdFlag, oEnMAC    run-mode controls
//   oCsnRam, oWrnRam      RAM chip select / write enable (active-low)
//   oModuleSel, oWtDtRam  RAM module select and write data
//   oLoadDone             pulse after the last word has been written
//   oLoadErr, iChkSum     checksum compare (only with COEFF_CHKSUM_EN)
//
// Build option: define COEFF_CHKSUM_EN to enable the load checksum.
// -----------------------------------------------------------------------------
module fir_coeff_sequencer #(
    parameter int unsigned SAMPLE_DIV  = 20,
    parameter int unsigned NUM_TAPS    = 10,
    parameter int unsigned NUM_MODULES = 4
) (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic        iLoadStart,
    input  logic        iRunEn,
    input  logic [1:0]  iRunSel,
    input  logic        iCoeffValid,
    input  logic [15:0] iCoeffData,
    input  logic [15:0] iChkSum,
    output logic        oCoeffReady,
    output logic        oEnSample600k,
    output logic        oCoeffUpdateFlag,
    output logic        oMemRdFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic        oEnMAC,
    output logic [1:0]  oModuleSel,
    output logic [15:0] oWtDtRam,
    output logic        oLoadDone,
    output logic        oLoadErr
);

    localparam int unsigned CNT_W     = $clog2(SAMPLE_DIV);
    localparam int unsigned TAP_W     = $clog2(NUM_TAPS);
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned NUM_WORDS = NUM_TAPS * NUM_MODULES;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [1:0]         mod_q, mod_d;
    logic               strobe_q, strobe_d;
    logic               ready_q, ready_d;
    logic               upd_q, upd_d;
    logic               memrd_q, memrd_d;
    logic               csn_q, csn_d;
    logic               wrn_q, wrn_d;
    logic               mac_q, mac_d;
    logic [1:0]         modsel_q, modsel_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               fire_c;
    logic               load_entry_c;
    logic               chk_bad_c;

    // A word transfers when upstream is valid and our registered ready is high.
    assign fire_c = iCoeffValid & ready_q;

    // Free-running sample divider; strobe registered off the terminal count.
    always_comb begin
        strobe_d = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d    = strobe_d ? '0 : cnt_q + CNT_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tap_d    = tap_q;
        mod_d    = mod_q;
        ready_d  = 1'b0;
        upd_d    = 1'b0;
        memrd_d  = 1'b0;
        csn_d    = 1'b1;
        wrn_d    = 1'b1;
        mac_d    = 1'b0;
        modsel_d = modsel_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iLoadStart)  state_d = ST_LOAD;
                else if (iRunEn) state_d = ST_RUN;
            end
            ST_LOAD: begin
                // iLoadStart is deliberately ignored here.
                if (fire_c) begin
                    csn_d    = 1'b0;
                    wrn_d    = 1'b0;
                    wdata_d  = iCoeffData;
                    modsel_d = mod_q;
                    idx_d    = idx_q + IDX_W'(1);
                    if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        tap_d = '0;
                        mod_d = mod_q + 2'd1;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                idx_d   = '0;
                tap_d   = '0;
                mod_d   = '0;
                // A checksum mismatch keeps the filter out of run mode.
                state_d = (iRunEn && !chk_bad_c) ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (iLoadStart)   state_d = ST_LOAD;
                else if (!iRunEn) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every load restarts at module 0, tap 0.
        if (load_entry_c) begin
            idx_d    = '0;
            tap_d    = '0;
            mod_d    = '0;
            modsel_d = '0;
        end

        case (state_d)
            ST_LOAD: begin
                upd_d   = 1'b1;
                ready_d = 1'b1;
            end
            ST_DONE: upd_d = 1'b1;
            ST_RUN: begin
                memrd_d  = 1'b1;
                mac_d    = 1'b1;
                csn_d    = 1'b0;
                wrn_d    = 1'b1;
                modsel_d = iRunSel;
            end
            default: ;
        endcase
    end

    assign load_entry_c = (state_d == ST_LOAD) && (state_q != ST_LOAD);

`ifdef COEFF_CHKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;

    // Modular sum of accepted words; error sticky until the next load.
    always_comb begin
        chk_bad_c = (state_q == ST_DONE) && (sum_q != iChkSum);
        sum_d     = sum_q;
        err_d     = err_q;
        if (load_entry_c) begin
            sum_d = '0;
            err_d = 1'b0;
        end else begin
            if (fire_c)    sum_d = sum_q + iCoeffData;
            if (chk_bad_c) err_d = 1'b1;
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign oLoadErr = err_q;
`else
    logic unused_chksum;

    assign unused_chksum = ^iChkSum;
    assign chk_bad_c     = 1'b0;
    assign oLoadErr      = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            tap_q    <= '0;
            mod_q    <= '0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            upd_q    <= 1'b0;
            memrd_q  <= 1'b0;
            csn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            mac_q    <= 1'b0;
            modsel_q <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tap_q    <= tap_d;
            mod_q    <= mod_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            upd_q    <= upd_d;
            memrd_q  <= memrd_d;
            csn_q    <= csn_d;
            wrn_q    <= wrn_d;
            mac_q    <= mac_d;
            modsel_q <= modsel_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

    assign oEnSample600k    = strobe_q;
    assign oCoeffReady      = ready_q;
    assign oCoeffUpdateFlag = upd_q;
    assign oMemRdFlag       = memrd_q;
    assign oCsnRam          = csn_q;
    assign oWrnRam          = wrn_q;
    assign oEnMAC           = mac_q;
    assign oModuleSel       = modsel_q;
    assign oWtDtRam         = wdata_q;
    assign oLoadDone        = done_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_sequencer
// Directed bench for fir_coeff_sequencer: sample strobe, back-to-back and
// throttled loads, run mode, load abort from run, reset mid-load, and the
// checksum option when COEFF_CHKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_fir_coeff_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iLoadStart = 1'b0;
    logic        iRunEn = 1'b0;
    logic [1:0]  iRunSel = 2'd0;
    logic        iCoeffValid = 1'b0;
    logic [15:0] iCoeffData = 16'h0;
    logic [15:0] iChkSum = 16'h0;
    logic        oCoeffReady, oEnSample600k, oCoeffUpdateFlag, oMemRdFlag;
    logic        oCsnRam, oWrnRam, oEnMAC, oLoadDone, oLoadErr;
    logic [1:0]  oModuleSel;
    logic [15:0] oWtDtRam;

    int errors = 0;
    int checks = 0;

    fir_coeff_sequencer dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iLoadStart       (iLoadStart),
        .iRunEn           (iRunEn),
        .iRunSel          (iRunSel),
        .iCoeffValid      (iCoeffValid),
        .iCoeffData       (iCoeffData),
        .iChkSum          (iChkSum),
        .oCoeffReady      (oCoeffReady),
        .oEnSample600k    (oEnSample600k),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oMemRdFlag       (oMemRdFlag),
        .oCsnRam          (oCsnRam),
        .oWrnRam          (oWrnRam),
        .oEnMAC           (oEnMAC),
        .oModuleSel       (oModuleSel),
        .oWtDtRam         (oWtDtRam),
        .oLoadDone        (oLoadDone),
        .oLoadErr         (oLoadErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Streams n words back-to-back; word i carries base+i at load index start+i.
    task automatic feed(input int start, input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            iCoeffValid = 1'b1;
            iCoeffData  = base + 16'(i);
            step();
            chk("wr_csn",   32'(oCsnRam), 32'd0);
            chk("wr_wrn",   32'(oWrnRam), 32'd0);
            chk("wr_data",  32'(oWtDtRam), 32'(base + 16'(i)));
            chk("wr_mod",   32'(oModuleSel), 32'((start + i) / 10));
            chk("wr_ready", 32'(oCoeffReady), 32'((start + i) < 39));
        end
        iCoeffValid = 1'b0;
        iCoeffData  = 16'h0;
    endtask

    task automatic pulse_load();
        iLoadStart = 1'b1;
        step();
        iLoadStart = 1'b0;
    endtask

    initial begin
        int n;
        logic exp_wr;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_csn",  32'(oCsnRam), 32'd1);
        chk("rst_wrn",  32'(oWrnRam), 32'd1);
        chk("rst_upd",  32'(oCoeffUpdateFlag), 32'd0);
        chk("rst_rdy",  32'(oCoeffReady), 32'd0);
        chk("rst_strb", 32'(oEnSample600k), 32'd0);
        chk("rst_data", 32'(oWtDtRam), 32'd0);

        // Idle 100 cycles: strobe at 20, 40, ... 100, outputs inactive
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            chk("strobe", 32'(oEnSample600k), 32'((k % 20) == 0));
            chk("idle_csn", 32'(oCsnRam), 32'd1);
            chk("idle_flags", 32'({oCoeffUpdateFlag, oMemRdFlag, oEnMAC, oLoadDone}), 32'd0);
        end

        // Back-to-back load of 0x0001..0x0028; iLoadStart mid-load ignored
        pulse_load();
        chk("ld_upd", 32'(oCoeffUpdateFlag), 32'd1);
        chk("ld_rdy", 32'(oCoeffReady), 32'd1);
        chk("ld_csn", 32'(oCsnRam), 32'd1);
        feed(0, 17, 16'h0001);
        iLoadStart = 1'b1;
        feed(17, 1, 16'h0012);
        iLoadStart = 1'b0;
        feed(18, 22, 16'h0013);
        chk("done_upd",   32'(oCoeffUpdateFlag), 32'd1);
        chk("done_rdy",   32'(oCoeffReady), 32'd0);
        chk("done_pulse", 32'(oLoadDone), 32'd0);
        step();
        chk("ldone_1", 32'(oLoadDone), 32'd1);
        chk("ldone_upd", 32'(oCoeffUpdateFlag), 32'd0);
        chk("ldone_csn", 32'(oCsnRam), 32'd1);
        chk("ldone_rd", 32'(oMemRdFlag), 32'd0);
        step();
        chk("ldone_0", 32'(oLoadDone), 32'd0);

        // Throttled load: valid toggles, data junk while valid is low
        pulse_load();
        n = 0;
        for (int i = 0; i < 80; i++) begin
            exp_wr      = ((i % 2) == 0);
            iCoeffValid = exp_wr;
            iCoeffData  = exp_wr ? 16'h0100 + 16'(n) : 16'hBEEF;
            step();
            chk("tg_csn", 32'(oCsnRam), 32'(!exp_wr));
            if (exp_wr) begin
                chk("tg_data", 32'(oWtDtRam), 32'(16'h0100 + 16'(n)));
                chk("tg_mod", 32'(oModuleSel), 32'(n / 10));
                n++;
            end
            chk("tg_rdy",  32'(oCoeffReady), 32'(i < 78));
            chk("tg_done", 32'(oLoadDone), 32'(i == 79));
        end
        iCoeffValid = 1'b0;
        chk("tg_count", 32'(n), 32'd40);

        // Load with run enabled (LOAD beats RUN in IDLE), then RUN
        iRunEn  = 1'b1;
        iRunSel = 2'd2;
        pulse_load();
        chk("lr_upd", 32'(oCoeffUpdateFlag), 32'd1);
        chk("lr_rd",  32'(oMemRdFlag), 32'd0);
        feed(0, 40, 16'h0001);
        step();
        chk("run_rd",   32'(oMemRdFlag), 32'd1);
        chk("run_mac",  32'(oEnMAC), 32'd1);
        chk("run_csn",  32'(oCsnRam), 32'd0);
        chk("run_wrn",  32'(oWrnRam), 32'd1);
        chk("run_sel",  32'(oModuleSel), 32'd2);
        chk("run_done", 32'(oLoadDone), 32'd1);
        iRunSel = 2'd1;
        #1;
        chk("run_sel_hold", 32'(oModuleSel), 32'd2);
        step();
        chk("run_sel_new", 32'(oModuleSel), 32'd1);

        // iLoadStart in RUN aborts to LOAD
        pulse_load();
        chk("ab_mac", 32'(oEnMAC), 32'd0);
        chk("ab_rd",  32'(oMemRdFlag), 32'd0);
        chk("ab_upd", 32'(oCoeffUpdateFlag), 32'd1);
        chk("ab_rdy", 32'(oCoeffReady), 32'd1);
        chk("ab_csn", 32'(oCsnRam), 32'd1);
        iRunEn = 1'b0;

        // Reset after word 17, asynchronously
        feed(0, 17, 16'h0A00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_csn",  32'(oCsnRam), 32'd1);
        chk("ar_wrn",  32'(oWrnRam), 32'd1);
        chk("ar_upd",  32'(oCoeffUpdateFlag), 32'd0);
        chk("ar_rdy",  32'(oCoeffReady), 32'd0);
        chk("ar_mod",  32'(oModuleSel), 32'd0);
        chk("ar_data", 32'(oWtDtRam), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_load();
        feed(0, 40, 16'h0B00);
        step();
        chk("rl_done", 32'(oLoadDone), 32'd1);
        chk("rl_rd",   32'(oMemRdFlag), 32'd0);

        // IDLE -> RUN on iRunEn, RUN -> IDLE when dropped
        iRunEn = 1'b1;
        step();
        chk("ir_rd", 32'(oMemRdFlag), 32'd1);
        iRunEn = 1'b0;
        step();
        chk("ri_rd",  32'(oMemRdFlag), 32'd0);
        chk("ri_mac", 32'(oEnMAC), 32'd0);
        chk("ri_csn", 32'(oCsnRam), 32'd1);

`ifdef COEFF_CHKSUM_EN
        // Sum of 1..40 is 0x0334: mismatch first, then match
        iRunEn  = 1'b1;
        iChkSum = 16'h0335;
        pulse_load();
        feed(0, 40, 16'h0001);
        step();
        chk("cs_done", 32'(oLoadDone), 32'd1);
        chk("cs_err",  32'(oLoadErr), 32'd1);
        chk("cs_rd",   32'(oMemRdFlag), 32'd0);
        step();
        chk("cs_hold", 32'(oLoadErr), 32'd1);
        iChkSum = 16'h0334;
        pulse_load();
        chk("cs_clr", 32'(oLoadErr), 32'd0);
        feed(0, 40, 16'h0001);
        step();
        chk("cs_ok_done", 32'(oLoadDone), 32'd1);
        chk("cs_ok_err",  32'(oLoadErr), 32'd0);
        chk("cs_ok_rd",   32'(oMemRdFlag), 32'd1);
        iRunEn = 1'b0;
`else
        chk("no_err", 32'(oLoadErr), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
